// File: rtl/contador4_checker.sv
// Passive reference-model checker for a 4-bit loadable up-counter: tracks the
// counter after a seeding load, compares Q each edge, and keeps error statistics.
module contador4_checker #(
  parameter int WIDTH        = 4,
  parameter int ERR_W        = 8,
  parameter int CHK_W        = 16,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enb,
  input  logic             modo,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] Q,
  input  logic             clr,
  output logic [WIDTH-1:0] exp_q,
  output logic             valid,
  output logic             err,
  output logic             fail,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CHK_W-1:0] chk_cnt,
  output logic             wrap,
  output logic [WIDTH-1:0] first_q,
  output logic [WIDTH-1:0] first_exp
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    HALT  = 2'b10
  } st_t;

  st_t  state, nxt;
  logic mis;

  assign mis = (Q != exp_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = (enb && modo) ? TRACK : IDLE;
      TRACK:   nxt = (mis && (STOP_ON_FAIL != 0)) ? HALT : TRACK;
      HALT:    nxt = HALT;
      default: nxt = IDLE;
    endcase
    if (clr) nxt = IDLE;
  end

  always_comb begin
    valid = (state == TRACK) || (state == HALT);
  end

  // Model and statistics. The model is never resynchronised to Q: after a
  // mismatch it keeps evolving from its own value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q     <= '0;
      err       <= 1'b0;
      fail      <= 1'b0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
      wrap      <= 1'b0;
      first_q   <= '0;
      first_exp <= '0;
    end else if (clr) begin
      exp_q     <= '0;
      err       <= 1'b0;
      fail      <= 1'b0;
      err_cnt   <= '0;
      chk_cnt   <= '0;
      wrap      <= 1'b0;
      first_q   <= '0;
      first_exp <= '0;
    end else begin
      err  <= 1'b0;
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (enb && modo) exp_q <= data;
        end
        TRACK: begin
          if (chk_cnt != '1) chk_cnt <= chk_cnt + CHK_W'(1);
          if (mis) begin
            err <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            if (!fail) begin
              fail      <= 1'b1;
              first_q   <= Q;
              first_exp <= exp_q;
            end
          end
          if (enb) begin
            if (modo) begin
              exp_q <= data;
            end else begin
              exp_q <= exp_q + WIDTH'(1);
              wrap  <= &exp_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/contador4_checker.md
# contador4_checker

Passive, synthesizable checker for the 4-bit loadable up-counter (`enb`, `modo`, `data`, `Q`). It sits beside the counter on the same wires the stimulus generator drives. It keeps a reference model of the counter and compares the counter's `Q` every cycle. It reports mismatches as a one-cycle pulse, a sticky fail flag, saturating statistics and a capture of the first failure. It drives nothing into the counter.

## Interface
- `WIDTH`, 4, counter width; `Q`, `data` and model width.
- `ERR_W`, 8, width of the saturating mismatch counter.
- `CHK_W`, 16, width of the saturating comparison counter.
- `STOP_ON_FAIL`, 0: 1 = enter HALT on the first mismatch; 0 = keep checking.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enb`  in  1  counter enable, observed.
- `modo`  in  1  counter mode, observed: 1 = load `data`, 0 = count up.
- `data`  in  WIDTH  counter load value, observed.
- `Q`  in  WIDTH  counter output under check.
- `clr`  in  1  synchronous clear of model and statistics; returns to IDLE.
- `exp_q`  out  WIDTH  model's expected `Q`.
- `valid`  out  1  high while the model is seeded (TRACK or HALT).
- `err`  out  1  one-cycle pulse per detected mismatch.
- `fail`  out  1  sticky: set on the first mismatch.
- `err_cnt`  out  ERR_W  mismatches seen, saturating.
- `chk_cnt`  out  CHK_W  comparisons performed, saturating.
- `wrap`  out  1  one-cycle pulse when the model counts from all-ones to 0.
- `first_q`  out  WIDTH  `Q` captured at the first mismatch.
- `first_exp`  out  WIDTH  `exp_q` captured at the first mismatch.

## Operation
- **Counter model, per rising edge:**
  - `enb`=1, `modo`=1: model ← `data`.
  - `enb`=1, `modo`=0: model ← (model+1) mod 2^WIDTH.
  - `enb`=0: hold.
- **States:** IDLE, TRACK, HALT. Encoded in 2 bits; the unused code returns to IDLE.
- **IDLE:**
  - No comparisons; `valid`=0.
  - First edge with `enb`=1 and `modo`=1: model ← `data`, go to TRACK.
  - Counting edges in IDLE are ignored.
- **TRACK:**
  - Each edge compares `Q` against `exp_q`, then applies the model rule.
  - Each comparison increments `chk_cnt`.
  - On mismatch:
    - `err` pulses and `err_cnt` increments.
    - If `fail` was 0: `fail`←1, `first_q`←`Q`, `first_exp`←`exp_q`.
    - If `STOP_ON_FAIL`=1: go to HALT.
- **Model after a mismatch:** keeps evolving from its own value. It is never resynchronised to `Q`.
- **HALT:**
  - All registers frozen; `err` and `wrap` are 0.
  - Only `clr` or reset leaves HALT.
- **`clr`:** has priority over every other action. State ← IDLE and every output ← its reset value, on the same edge.
- **Saturation:** `err_cnt` and `chk_cnt` stop at all-ones; no wrap.
- **`wrap`:** pulses only for a count step from 2^WIDTH−1. A load of 0 does not pulse it.

## Timing
- **Reset values:** state=IDLE; `exp_q`=0; `valid`=0; `err`=0; `fail`=0; `err_cnt`=0; `chk_cnt`=0; `wrap`=0; `first_q`=0; `first_exp`=0.
- **Comparison alignment:**
  - At edge k, `Q` sampled just before the edge (the counter's update from edge k−1) is compared with `exp_q` (the model's update from edge k−1).
  - `err` is visible for the cycle following edge k.
- **Latency:**
  - Seeding load at edge k0: `valid` high after k0.
  - First comparison at k0+1.
- **Simultaneous events:** a mismatch and a load on the same edge both take effect. The comparison uses the pre-load `exp_q`.
- **Reset mid-operation:**
  - Asserting `reset_n` clears immediately, without waiting for `clk`.
  - Deassertion is seen at the next edge; the checker restarts in IDLE.

## Test plan
- **Reset:** hold `reset_n`=0, drive `Q`=5 for 3 cycles -> all outputs at reset values, `err` never high.
- **Seed and count:**
  - Stimulus: `enb`=1, `modo`=1, `data`=0 for one edge; then `modo`=0 for 20 edges; correct counter.
  - Required: `valid`=1; `exp_q` runs 0..15, 0..3; `wrap` pulses once; `err_cnt`=0; `chk_cnt`=20.
- **Single fault:**
  - Stimulus: seeded at 3, counting; force `Q`=9 on one cycle where 7 is expected.
  - Required: one `err` pulse; `fail`=1; `first_q`=9; `first_exp`=7; `err_cnt`=1; next cycle no error.
- **Hold:** `enb`=0 for 5 edges with `Q` steady at 4 -> `exp_q` stays 4, `chk_cnt` +5, no `err`.
- **STOP_ON_FAIL=1:**
  - Stimulus: inject a mismatch, then 10 more faulty cycles; then `clr`=1 for one edge.
  - Required: `err_cnt`=1 and `chk_cnt` frozen through the faulty cycles; after `clr`, state=IDLE and outputs back to reset values.
- **Saturation and async reset:**
  - Stimulus (ERR_W=2): hold `Q` stuck at 0 while counting for 6 edges; then pulse `reset_n` low between edges.
  - Required: `err_cnt` ends at 3; outputs clear before the next rising edge.
